pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Next-PC controller for the pipelined MIPS fetch stage; drives data/isPCWrite of pc register.
//  Picks sequential / branch / jump / exception target and honours hazard-unit stalls.
//  Keeps a redirect that arrives during a stall and applies it once the stall releases.
//  Emits a one-cycle IF flush on every applied redirect and counts stall cycles.
// PARAMETERS
//  RESET_VECTOR  32'h0000_3000  PC loaded in the first cycle after reset
//  EXC_VECTOR    32'h0000_4180  exception entry address
//  CNT_W         16             width of stall_cnt (saturating)
// PORTS
//  clk          in   1   system clock, rising edge
//  PCReSet      in   1   asynchronous, active-high reset
//  pc_cur       in   32  current PC (pc register output)
//  stall        in   1   hazard unit: hold PC this cycle
//  branch_taken in   1   branch resolved taken this cycle
//  branch_tgt   in   32  branch target
//  jump         in   1   j/jal/jr this cycle
//  jump_tgt     in   32  jump target
//  exc_req      in   1   exception request (one-cycle pulse)
//  isPCWrite    out  1   PC write enable (registered)
//  pc_next      out  32  value written to PC (registered)
//  flush_if     out  1   squash instruction in IF/ID (registered)
//  seq_state    out  2   current FSM state
//  stall_cnt    out  CNT_W  cycles spent with stall=1 since reset, saturates at all-ones
// BEHAVIOUR
//  Reset (async): state=BOOT, isPCWrite=0, pc_next=RESET_VECTOR, flush_if=0, stall_cnt=0, pend_vld=0.
//  All outputs registered: decision made in cycle N appears in N+1; PC updates at edge N+2.
//  pc_next[1:0] forced to 2'b00 always; PC+4 wraps modulo 2^32 (FFFF_FFFC -> 0000_0000).
//  Priority when several requests coincide: exc_req > jump > branch_taken > sequential.
//  BOOT(0): isPCWrite=1, pc_next=RESET_VECTOR; -> RUN. Inputs ignored.
//  RUN(1), stall=0: isPCWrite=1; pc_next=highest-priority target else pc_cur+4;
//    flush_if=1 iff a redirect (exc/jump/branch) was applied.
//  RUN, stall=1: isPCWrite=0, flush_if=0; if any redirect present, latch it (pend_tgt,
//    pend_pri) and -> HOLD; else stay RUN.
//  HOLD(2), stall=1: isPCWrite=0; new redirect replaces pending only if priority >= pending.
//  HOLD, stall=0: isPCWrite=1, pc_next=pend_tgt (or newer same-cycle request if higher
//    priority), flush_if=1, pend_vld cleared; -> RUN.
//  stall_cnt: +1 every cycle stall=1 in RUN/HOLD/DSLOT; holds at 2^CNT_W-1.
//  PCReSet mid-operation discards pending redirect and any delay-slot state; restarts in BOOT.
// CONFIGURATION
//  Macro PCSEQ_DELAY_SLOT_EN:
//   defined: MIPS branch delay slot. Jump/branch in RUN (stall=0) writes pc_cur+4
//    (flush_if=0), latches target, -> DSLOT(3). DSLOT, stall=0: write target, flush_if=0,
//    -> RUN; stall=1: hold and count. exc_req in any state bypasses the slot: writes
//    EXC_VECTOR at once, flush_if=1, discards latched target. HOLD->RUN release of a
//    jump/branch also passes through DSLOT.
//   undefined: no DSLOT state (encoding 3 unused); redirects applied immediately as above.
// TESTING
//  1 Release reset, no requests: pc_next=3000 with isPCWrite=1, then 3004, 3008 each cycle.
//  2 pc_cur=3010, branch_taken=1, branch_tgt=3100, stall=0: next cycle pc_next=3100,
//    isPCWrite=1, flush_if=1 (with macro: 3014 first, then 3100, flush_if=0).
//  3 stall=1 for 3 cycles, jump_tgt=3200 in 1st stall cycle: isPCWrite=0 x3, state=HOLD,
//    on release pc_next=3200 flush_if=1; stall_cnt=3.
//  4 Same cycle exc_req=1, jump=1, branch_taken=1: pc_next=4180, flush_if=1; in HOLD a later
//    branch does not override pending jump, a later exc does.
//  5 pc_cur=FFFF_FFFC, no requests: pc_next=0000_0000; branch_tgt=3103 -> pc_next=3100.
//  6 PCReSet asserted while in HOLD with pending target: outputs reset immediately, BOOT
//    reloads 3000, pending target never written; stall_cnt saturates at FFFF after 65535+ stalls.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC sequencer for the fetch stage; optional delay slot via PCSEQ_DELAY_SLOT_EN
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_4180,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             PCReSet,
  input  logic [31:0]      pc_cur,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_tgt,
  input  logic             jump,
  input  logic [31:0]      jump_tgt,
  input  logic             exc_req,
  output logic             isPCWrite,
  output logic [31:0]      pc_next,
  output logic             flush_if,
  output logic [1:0]       seq_state,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DSLOT = 2'd3
  } state_t;

  // Redirect priorities; 0 means no redirect this cycle.
  localparam logic [1:0] PRI_NONE = 2'd0;
  localparam logic [1:0] PRI_BR   = 2'd1;
  localparam logic [1:0] PRI_JMP  = 2'd2;
  localparam logic [1:0] PRI_EXC  = 2'd3;

  state_t      state, state_nx;

  logic        pend_vld, pend_vld_nx;
  logic [1:0]  pend_pri, pend_pri_nx;
  logic [31:0] pend_tgt, pend_tgt_nx;

  logic        write_nx;
  logic [31:0] pc_nx;
  logic        flush_nx;

  logic [1:0]  req_pri;
  logic [31:0] req_tgt;
  logic [31:0] seq_pc;
  logic [1:0]  win_pri;
  logic [31:0] win_tgt;

  // Instruction addresses are word aligned; low two bits are never emitted.
  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  assign seq_pc = align_word(pc_cur + 32'd4);

  // Pick the highest-priority redirect requested this cycle.
  always_comb begin
    req_pri = PRI_NONE;
    req_tgt = seq_pc;
    if (exc_req) begin
      req_pri = PRI_EXC;
      req_tgt = EXC_VECTOR;
    end else if (jump) begin
      req_pri = PRI_JMP;
      req_tgt = align_word(jump_tgt);
    end else if (branch_taken) begin
      req_pri = PRI_BR;
      req_tgt = align_word(branch_tgt);
    end
  end

  // On stall release a same-cycle request wins only if strictly stronger than the pending one.
  always_comb begin
    win_pri = pend_pri;
    win_tgt = pend_tgt;
    if (req_pri > pend_pri) begin
      win_pri = req_pri;
      win_tgt = req_tgt;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge PCReSet) begin
    if (PCReSet) begin
      state <= ST_BOOT;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decision.
  always_comb begin
    state_nx = state;
    case (state)
      ST_BOOT: state_nx = ST_RUN;
      ST_RUN: begin
        if (stall) begin
          state_nx = (req_pri != PRI_NONE) ? ST_HOLD : ST_RUN;
        end else begin
`ifdef PCSEQ_DELAY_SLOT_EN
          state_nx = (req_pri == PRI_BR || req_pri == PRI_JMP) ? ST_DSLOT : ST_RUN;
`else
          state_nx = ST_RUN;
`endif
        end
      end
      ST_HOLD: begin
        if (stall) begin
          state_nx = ST_HOLD;
        end else begin
`ifdef PCSEQ_DELAY_SLOT_EN
          state_nx = (win_pri == PRI_EXC) ? ST_RUN : ST_DSLOT;
`else
          state_nx = ST_RUN;
`endif
        end
      end
      ST_DSLOT: begin
`ifdef PCSEQ_DELAY_SLOT_EN
        if (stall) begin
          state_nx = exc_req ? ST_HOLD : ST_DSLOT;
        end else begin
          state_nx = ST_RUN;
        end
`else
        state_nx = ST_RUN;
`endif
      end
      default: state_nx = ST_BOOT;
    endcase
  end

  // Output and pending-redirect decisions for the next cycle.
  always_comb begin
    write_nx    = 1'b0;
    pc_nx       = pc_next;
    flush_nx    = 1'b0;
    pend_vld_nx = pend_vld;
    pend_pri_nx = pend_pri;
    pend_tgt_nx = pend_tgt;
    case (state)
      ST_BOOT: begin
        write_nx    = 1'b1;
        pc_nx       = RESET_VECTOR;
        pend_vld_nx = 1'b0;
        pend_pri_nx = PRI_NONE;
      end
      ST_RUN: begin
        if (stall) begin
          if (req_pri != PRI_NONE) begin
            pend_vld_nx = 1'b1;
            pend_pri_nx = req_pri;
            pend_tgt_nx = req_tgt;
          end
        end else begin
          write_nx = 1'b1;
`ifdef PCSEQ_DELAY_SLOT_EN
          if (req_pri == PRI_EXC) begin
            pc_nx    = EXC_VECTOR;
            flush_nx = 1'b1;
          end else begin
            pc_nx = seq_pc;
            if (req_pri != PRI_NONE) begin
              pend_vld_nx = 1'b1;
              pend_pri_nx = req_pri;
              pend_tgt_nx = req_tgt;
            end
          end
`else
          pc_nx    = req_tgt;
          flush_nx = (req_pri != PRI_NONE);
`endif
        end
      end
      ST_HOLD: begin
        if (stall) begin
          if (req_pri != PRI_NONE && req_pri >= pend_pri) begin
            pend_pri_nx = req_pri;
            pend_tgt_nx = req_tgt;
          end
        end else begin
          write_nx = 1'b1;
`ifdef PCSEQ_DELAY_SLOT_EN
          if (win_pri == PRI_EXC) begin
            pc_nx       = EXC_VECTOR;
            flush_nx    = 1'b1;
            pend_vld_nx = 1'b0;
            pend_pri_nx = PRI_NONE;
          end else begin
            pc_nx       = seq_pc;
            pend_vld_nx = 1'b1;
            pend_pri_nx = win_pri;
            pend_tgt_nx = win_tgt;
          end
`else
          pc_nx       = win_tgt;
          flush_nx    = 1'b1;
          pend_vld_nx = 1'b0;
          pend_pri_nx = PRI_NONE;
`endif
        end
      end
      ST_DSLOT: begin
`ifdef PCSEQ_DELAY_SLOT_EN
        if (exc_req) begin
          if (stall) begin
            pend_pri_nx = PRI_EXC;
            pend_tgt_nx = EXC_VECTOR;
          end else begin
            write_nx    = 1'b1;
            pc_nx       = EXC_VECTOR;
            flush_nx    = 1'b1;
            pend_vld_nx = 1'b0;
            pend_pri_nx = PRI_NONE;
          end
        end else if (!stall) begin
          write_nx    = 1'b1;
          pc_nx       = pend_tgt;
          pend_vld_nx = 1'b0;
          pend_pri_nx = PRI_NONE;
        end
`else
        pend_vld_nx = 1'b0;
        pend_pri_nx = PRI_NONE;
`endif
      end
      default: begin
        pend_vld_nx = 1'b0;
        pend_pri_nx = PRI_NONE;
      end
    endcase
  end

  // Registered outputs and pending redirect.
  always_ff @(posedge clk or posedge PCReSet) begin
    if (PCReSet) begin
      isPCWrite <= 1'b0;
      pc_next   <= RESET_VECTOR;
      flush_if  <= 1'b0;
      pend_vld  <= 1'b0;
      pend_pri  <= PRI_NONE;
      pend_tgt  <= RESET_VECTOR;
    end else begin
      isPCWrite <= write_nx;
      pc_next   <= pc_nx;
      flush_if  <= flush_nx;
      pend_vld  <= pend_vld_nx;
      pend_pri  <= pend_pri_nx;
      pend_tgt  <= pend_tgt_nx;
    end
  end

  // Saturating count of stalled cycles outside BOOT.
  always_ff @(posedge clk or posedge PCReSet) begin
    if (PCReSet) begin
      stall_cnt <= '0;
    end else if (stall && state != ST_BOOT && stall_cnt != {CNT_W{1'b1}}) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign seq_state = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized and directed bench for pc_sequencer against a behavioural model
module tb_pc_sequencer;

  logic        clk;
  logic        PCReSet;
  logic [31:0] pc_cur;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_tgt;
  logic        jump;
  logic [31:0] jump_tgt;
  logic        exc_req;
  logic        isPCWrite;
  logic [31:0] pc_next;
  logic        flush_if;
  logic [1:0]  seq_state;
  logic [15:0] stall_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: booted flag, one pending redirect, expected outputs.
  bit          m_boot;
  bit          m_pend;
  int          m_ppri;
  logic [31:0] m_ptgt;
  logic        m_wr;
  logic [31:0] m_pc;
  logic        m_fl;
  int          m_cnt;

  pc_sequencer dut (
    .clk(clk), .PCReSet(PCReSet), .pc_cur(pc_cur), .stall(stall),
    .branch_taken(branch_taken), .branch_tgt(branch_tgt), .jump(jump),
    .jump_tgt(jump_tgt), .exc_req(exc_req), .isPCWrite(isPCWrite),
    .pc_next(pc_next), .flush_if(flush_if), .seq_state(seq_state),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot = 1; m_pend = 0; m_ppri = 0; m_ptgt = 0;
    m_wr = 0; m_pc = 32'h0000_3000; m_fl = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    int pri;
    logic [31:0] tgt;
    pri = exc_req ? 3 : jump ? 2 : branch_taken ? 1 : 0;
    tgt = exc_req ? 32'h0000_4180 : jump ? jump_tgt : branch_tgt;
    tgt = tgt & 32'hFFFF_FFFC;
    if (m_boot) begin
      m_wr = 1; m_pc = 32'h0000_3000; m_fl = 0; m_boot = 0;
    end else begin
      if (stall && m_cnt < 65535) m_cnt++;
      if (stall) begin
        m_wr = 0; m_fl = 0;
        if (pri != 0 && (!m_pend || pri >= m_ppri)) begin
          m_pend = 1; m_ppri = pri; m_ptgt = tgt;
        end
      end else begin
        m_wr = 1;
        if (m_pend) begin
          m_pc = (pri > m_ppri) ? tgt : m_ptgt;
          m_fl = 1; m_pend = 0;
        end else if (pri != 0) begin
          m_pc = tgt; m_fl = 1;
        end else begin
          m_pc = (pc_cur + 32'd4) & 32'hFFFF_FFFC; m_fl = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_state;
    exp_state = m_boot ? 32'd0 : (m_pend ? 32'd2 : 32'd1);
    chk({tag, "_wr"}, {31'd0, isPCWrite}, {31'd0, m_wr});
    chk({tag, "_pc"}, pc_next, m_pc);
    chk({tag, "_fl"}, {31'd0, flush_if}, {31'd0, m_fl});
    chk({tag, "_st"}, {30'd0, seq_state}, exp_state);
    chk({tag, "_cnt"}, {16'd0, stall_cnt}, m_cnt[31:0]);
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic clear_req();
    stall = 0; branch_taken = 0; jump = 0; exc_req = 0;
  endtask

  initial begin
    PCReSet = 1; pc_cur = 0; branch_tgt = 0; jump_tgt = 0;
    clear_req();
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    PCReSet = 0;

    // Boot then sequential fetch
    step("boot");
    chk("boot_pc3000", pc_next, 32'h0000_3000);
    pc_cur = 32'h0000_3000; step("seq1");
    chk("seq_pc3004", pc_next, 32'h0000_3004);
    pc_cur = 32'h0000_3004; step("seq2");
    chk("seq_pc3008", pc_next, 32'h0000_3008);

    // Taken branch
    pc_cur = 32'h0000_3010; branch_taken = 1; branch_tgt = 32'h0000_3100;
    step("br");
    chk("br_pc3100", pc_next, 32'h0000_3100);
    chk("br_flush", {31'd0, flush_if}, 32'd1);
    clear_req();

    // Jump arriving in first of three stall cycles
    pc_cur = 32'h0000_3100; stall = 1; jump = 1; jump_tgt = 32'h0000_3200;
    step("st1");
    jump = 0;
    step("st2");
    step("st3");
    chk("hold_state", {30'd0, seq_state}, 32'd2);
    chk("hold_nowr", {31'd0, isPCWrite}, 32'd0);
    stall = 0;
    step("rel");
    chk("rel_pc3200", pc_next, 32'h0000_3200);
    chk("rel_flush", {31'd0, flush_if}, 32'd1);
    chk("rel_cnt3", {16'd0, stall_cnt}, 32'd3);

    // Coincident requests, then priority of replacements while held
    exc_req = 1; jump = 1; branch_taken = 1; jump_tgt = 32'h0000_3300; branch_tgt = 32'h0000_3400;
    step("all3");
    chk("all3_exc", pc_next, 32'h0000_4180);
    clear_req();
    stall = 1; jump = 1; step("hj");
    jump = 0; branch_taken = 1; step("hb");
    branch_taken = 0; stall = 0; step("hjrel");
    chk("hold_jump_kept", pc_next, 32'h0000_3300);
    stall = 1; jump = 1; step("hj2");
    jump = 0; exc_req = 1; step("he");
    exc_req = 0; stall = 0; step("herel");
    chk("hold_exc_wins", pc_next, 32'h0000_4180);

    // Wrap and alignment
    pc_cur = 32'hFFFF_FFFC; step("wrap");
    chk("wrap_zero", pc_next, 32'h0000_0000);
    branch_taken = 1; branch_tgt = 32'h0000_3103; step("align");
    chk("align_3100", pc_next, 32'h0000_3100);
    clear_req();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      stall        = ($urandom_range(0, 9) < 3);
      exc_req      = ($urandom_range(0, 19) == 0);
      jump         = ($urandom_range(0, 7) == 0);
      branch_taken = ($urandom_range(0, 5) == 0);
      jump_tgt     = $urandom;
      branch_tgt   = $urandom;
      pc_cur       = ($urandom_range(0, 3) == 0) ? $urandom : m_pc;
      step("rnd");
    end
    clear_req();

    // Reset while a redirect is pending
    pc_cur = 32'h0000_3500; stall = 1; jump = 1; jump_tgt = 32'h0000_3600;
    step("prerst");
    chk("prerst_hold", {30'd0, seq_state}, 32'd2);
    #2;
    PCReSet = 1;
    #1;
    model_reset();
    check_all("midrst");
    chk("midrst_pc", pc_next, 32'h0000_3000);
    @(posedge clk);
    #1;
    PCReSet = 0;
    clear_req();
    step("reboot");
    chk("reboot_3000", pc_next, 32'h0000_3000);
    pc_cur = 32'h0000_3000; step("postrst");
    chk("postrst_3004", pc_next, 32'h0000_3004);
    chk("postrst_noflush", {31'd0, flush_if}, 32'd0);

    // Saturation of the stall counter
    stall = 1;
    for (int i = 0; i < 65540; i++) begin
      model_step();
      @(posedge clk);
    end
    #1;
    check_all("sat");
    chk("sat_ffff", {16'd0, stall_cnt}, 32'h0000_FFFF);
    stall = 0;
    step("satrel");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
